// File: rtl/btb_assoc_if.sv
// Fetch/execute bus of the set-associative BTB: lookup request/prediction
// plus the training strobe from execute. The BTB sits on the slave modport.
interface btb_assoc_if #(
  parameter int PC_W = 16
);
  // Lookup side
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] npc_predict;
  logic            hit;
  logic            pred_taken;
  // Training side
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;

  modport master (
    output pc, upd_valid, upd_pc, upd_taken, upd_target,
    input  npc_predict, hit, pred_taken
  );

  modport slave (
    input  pc, upd_valid, upd_pc, upd_taken, upd_target,
    output npc_predict, hit, pred_taken
  );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with per-set round-robin replacement.
// Lookup is combinational (read-old on same-cycle update); training from execute
// lands on the next rising edge. Optional macro BTB_ASSOC_CTR_EN adds a 2-bit
// hysteresis counter per entry; without it a not-taken hit invalidates the entry.
module btb_assoc #(
  parameter int PC_W    = 16,
  parameter int INDEX_W = 6,
  parameter int WAYS    = 2
) (
  input logic        clk,
  input logic        rst,
  btb_assoc_if.slave bus
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = PC_W - INDEX_W - 2;
  localparam int TGT_W = PC_W - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef logic [WAY_W-1:0] way_t;

  // Entry storage; only valid (and ctr) carry a reset
  logic             valid_q [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [TGT_W-1:0] tgt_q   [SETS][WAYS];
`ifdef BTB_ASSOC_CTR_EN
  logic [1:0]       ctr_q   [SETS][WAYS];
`endif

  // Lookup decode
  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit;
  way_t               lk_way;
  logic               lk_taken;

  // Update decode
  logic [INDEX_W-1:0] up_idx;
  logic [TAG_W-1:0]   up_tag;
  logic               up_hit;
  way_t               up_hit_way;
  logic               up_free;
  way_t               up_free_way;
  way_t               rr_cur;

  // Write control for the single way touched by an update
  logic               wr_en;
  way_t               wr_way;
  logic               wr_valid;
  logic               wr_tag_en;
  logic               wr_tgt_en;
  logic               rr_adv;
`ifdef BTB_ASSOC_CTR_EN
  logic [1:0]         wr_ctr;
  logic [1:0]         up_ctr;
`endif

  // Bits that are architecturally zero or discarded
  logic unused_low_bits;
  assign unused_low_bits = ^{bus.pc[1:0], bus.upd_pc[1:0], bus.upd_target[1:0]};

  assign lk_idx = bus.pc[INDEX_W+1:2];
  assign lk_tag = bus.pc[PC_W-1:INDEX_W+2];
  assign up_idx = bus.upd_pc[INDEX_W+1:2];
  assign up_tag = bus.upd_pc[PC_W-1:INDEX_W+2];

  // Lookup tag match across all ways of the fetch set
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lk_hit = 1'b1;
        lk_way = way_t'(w);
      end
    end
  end

`ifdef BTB_ASSOC_CTR_EN
  assign lk_taken = lk_hit & ctr_q[lk_idx][lk_way][1];
  assign up_ctr   = ctr_q[up_idx][up_hit_way];
`else
  assign lk_taken = lk_hit;
`endif

  assign bus.hit         = lk_hit;
  assign bus.pred_taken  = lk_taken;
  assign bus.npc_predict = lk_taken ? {tgt_q[lk_idx][lk_way], 2'b00}
                                    : bus.pc + PC_W'(4);

  // Training-set tag match and lowest-numbered invalid way
  always_comb begin
    up_hit      = 1'b0;
    up_hit_way  = '0;
    up_free     = 1'b0;
    up_free_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
        up_hit     = 1'b1;
        up_hit_way = way_t'(w);
      end
      if (!valid_q[up_idx][w] && !up_free) begin
        up_free     = 1'b1;
        up_free_way = way_t'(w);
      end
    end
  end

  // Decide which way an update writes and what it writes
  always_comb begin
    wr_en     = 1'b0;
    wr_way    = up_hit_way;
    wr_valid  = 1'b1;
    wr_tag_en = 1'b0;
    wr_tgt_en = 1'b0;
    rr_adv    = 1'b0;
`ifdef BTB_ASSOC_CTR_EN
    wr_ctr    = 2'b10;
`endif
    if (bus.upd_valid) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (bus.upd_taken) begin
          wr_tgt_en = 1'b1;
`ifdef BTB_ASSOC_CTR_EN
          wr_ctr = (up_ctr == 2'b11) ? 2'b11 : up_ctr + 2'd1;
`endif
        end else begin
`ifdef BTB_ASSOC_CTR_EN
          wr_ctr = (up_ctr == 2'b00) ? 2'b00 : up_ctr - 2'd1;
`else
          wr_valid = 1'b0;
`endif
        end
      end else if (bus.upd_taken) begin
        wr_en     = 1'b1;
        wr_way    = up_free ? up_free_way : rr_cur;
        wr_tag_en = 1'b1;
        wr_tgt_en = 1'b1;
        rr_adv    = !up_free;
      end
    end
  end

  // Entry state: reset clears valid/ctr and wins over a same-cycle update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
`ifdef BTB_ASSOC_CTR_EN
          ctr_q[s][w]   <= '0;
`endif
        end
      end
    end else if (wr_en) begin
      valid_q[up_idx][wr_way] <= wr_valid;
      if (wr_tag_en) begin
        tag_q[up_idx][wr_way] <= up_tag;
      end
      if (wr_tgt_en) begin
        tgt_q[up_idx][wr_way] <= bus.upd_target[PC_W-1:2];
      end
`ifdef BTB_ASSOC_CTR_EN
      ctr_q[up_idx][wr_way] <= wr_ctr;
`endif
    end
  end

  if (WAYS > 1) begin : g_rr
    way_t rr_q [SETS];

    // Round-robin pointer advances only when a full set is replaced
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned s = 0; s < SETS; s++) begin
          rr_q[s] <= '0;
        end
      end else if (rr_adv) begin
        rr_q[up_idx] <= rr_q[up_idx] + way_t'(1);
      end
    end

    assign rr_cur = rr_q[up_idx];
  end else begin : g_no_rr
    logic unused_rr_adv;
    assign unused_rr_adv = rr_adv;
    assign rr_cur        = '0;
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc (PC_W=16, INDEX_W=6, WAYS=2). Table of
// lookup/update vectors with expected lookup results, plus a reset sequence.
// Covers both BTB_ASSOC_CTR_EN builds via matching ifdef sections.
module tb_btb_assoc;

  localparam int PC_W = 16;

  logic clk = 1'b0;
  logic rst;

  btb_assoc_if #(.PC_W(PC_W)) bus ();

  btb_assoc #(.PC_W(PC_W), .INDEX_W(6), .WAYS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            upd;
    logic [PC_W-1:0] upd_pc;
    logic            taken;
    logic [PC_W-1:0] tgt;
    logic [PC_W-1:0] pc;
    logic            hit;
    logic            pt;
    logic [PC_W-1:0] npc;
  } vec_t;

  typedef struct {
    logic            hit;
    logic            pt;
    logic [PC_W-1:0] npc;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(logic u, logic [PC_W-1:0] up, logic t, logic [PC_W-1:0] tg,
                              logic [PC_W-1:0] p, logic h, logic pt, logic [PC_W-1:0] n);
    vec_t v;
    v = '{u, up, t, tg, p, h, pt, n};
    tbl.push_back(v);
  endfunction

  task automatic check_out(input string nm);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (bus.hit !== e.hit) begin
      n_bad++;
      $display("FAIL %s hit: got %b want %b", nm, bus.hit, e.hit);
    end
    n_cmp++;
    if (bus.pred_taken !== e.pt) begin
      n_bad++;
      $display("FAIL %s pred_taken: got %b want %b", nm, bus.pred_taken, e.pt);
    end
    n_cmp++;
    if (bus.npc_predict !== e.npc) begin
      n_bad++;
      $display("FAIL %s npc: got %h want %h", nm, bus.npc_predict, e.npc);
    end
  endtask

  // Drive one cycle of lookup (+ optional update) and check the pre-edge lookup
  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    @(negedge clk);
    bus.pc         = v.pc;
    bus.upd_valid  = v.upd;
    bus.upd_pc     = v.upd_pc;
    bus.upd_taken  = v.taken;
    bus.upd_target = v.tgt;
    e = '{v.hit, v.pt, v.npc};
    exp_q.push_back(e);
    #2;
    check_out(nm);
  endtask

  task automatic lookup(input logic [PC_W-1:0] p, input logic h, input logic pt,
                        input logic [PC_W-1:0] n, input string nm);
    vec_t v;
    v = '{1'b0, '0, 1'b0, '0, p, h, pt, n};
    apply(v, nm);
  endtask

  initial begin
    // Common part: reset outputs, allocation, read-old, rr replacement
    add(0, 16'h0000, 0, 16'h0000, 16'h0100, 0, 0, 16'h0104);
    add(0, 16'h0000, 0, 16'h0000, 16'hFFFC, 0, 0, 16'h0000);
    add(1, 16'h0100, 1, 16'h0200, 16'h0100, 0, 0, 16'h0104);
    add(0, 16'h0000, 0, 16'h0000, 16'h0100, 1, 1, 16'h0200);
    add(1, 16'h0200, 1, 16'h0A00, 16'h0200, 0, 0, 16'h0204);
    add(0, 16'h0000, 0, 16'h0000, 16'h0200, 1, 1, 16'h0A00);
    add(1, 16'h0300, 1, 16'h0B00, 16'h0300, 0, 0, 16'h0304);
    add(0, 16'h0000, 0, 16'h0000, 16'h0100, 0, 0, 16'h0104);
    add(0, 16'h0000, 0, 16'h0000, 16'h0300, 1, 1, 16'h0B00);
    add(1, 16'h0400, 1, 16'h0C00, 16'h0200, 1, 1, 16'h0A00);
    add(0, 16'h0000, 0, 16'h0000, 16'h0200, 0, 0, 16'h0204);
    add(0, 16'h0000, 0, 16'h0000, 16'h0400, 1, 1, 16'h0C00);
    add(1, 16'h0500, 0, 16'h0900, 16'h0500, 0, 0, 16'h0504);
    add(0, 16'h0000, 0, 16'h0000, 16'h0500, 0, 0, 16'h0504);
    add(0, 16'h0000, 0, 16'h0000, 16'h0300, 1, 1, 16'h0B00);
    add(1, 16'h0300, 1, 16'h0D03, 16'h0300, 1, 1, 16'h0B00);
    add(0, 16'h0000, 0, 16'h0000, 16'h0300, 1, 1, 16'h0D00);
    add(1, 16'h0104, 1, 16'h1234, 16'h0104, 0, 0, 16'h0108);
    add(0, 16'h0000, 0, 16'h0000, 16'h0104, 1, 1, 16'h1234);
`ifdef BTB_ASSOC_CTR_EN
    // Hysteresis on 0x0400 (starts weakly taken)
    add(1, 16'h0400, 1, 16'h0C00, 16'h0400, 1, 1, 16'h0C00);
    add(1, 16'h0400, 1, 16'h0C00, 16'h0400, 1, 1, 16'h0C00);
    add(1, 16'h0400, 0, 16'h0000, 16'h0400, 1, 1, 16'h0C00);
    add(0, 16'h0000, 0, 16'h0000, 16'h0400, 1, 1, 16'h0C00);
    add(1, 16'h0400, 0, 16'h0000, 16'h0400, 1, 1, 16'h0C00);
    add(0, 16'h0000, 0, 16'h0000, 16'h0400, 1, 0, 16'h0404);
    add(1, 16'h0400, 0, 16'h0000, 16'h0400, 1, 0, 16'h0404);
    add(1, 16'h0400, 0, 16'h0000, 16'h0400, 1, 0, 16'h0404);
    add(1, 16'h0400, 1, 16'h0C40, 16'h0400, 1, 0, 16'h0404);
    add(0, 16'h0000, 0, 16'h0000, 16'h0400, 1, 0, 16'h0404);
    add(1, 16'h0400, 1, 16'h0C40, 16'h0400, 1, 0, 16'h0404);
    add(0, 16'h0000, 0, 16'h0000, 16'h0400, 1, 1, 16'h0C40);
`else
    // Not-taken hit invalidates; free way preferred over rr; rr then advances
    add(1, 16'h0400, 0, 16'h0000, 16'h0400, 1, 1, 16'h0C00);
    add(0, 16'h0000, 0, 16'h0000, 16'h0400, 0, 0, 16'h0404);
    add(1, 16'h0600, 1, 16'h0E00, 16'h0300, 1, 1, 16'h0D00);
    add(0, 16'h0000, 0, 16'h0000, 16'h0600, 1, 1, 16'h0E00);
    add(0, 16'h0000, 0, 16'h0000, 16'h0300, 1, 1, 16'h0D00);
    add(1, 16'h0700, 1, 16'h0F00, 16'h0700, 0, 0, 16'h0704);
    add(0, 16'h0000, 0, 16'h0000, 16'h0300, 0, 0, 16'h0304);
    add(0, 16'h0000, 0, 16'h0000, 16'h0600, 1, 1, 16'h0E00);
    add(0, 16'h0000, 0, 16'h0000, 16'h0700, 1, 1, 16'h0F00);
`endif

    rst            = 1'b1;
    bus.pc         = '0;
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_taken  = 1'b0;
    bus.upd_target = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset with a same-cycle taken update: nothing learned survives
    @(negedge clk);
    rst            = 1'b1;
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = 16'h0500;
    bus.upd_taken  = 1'b1;
    bus.upd_target = 16'h0900;
    bus.pc         = 16'h0300;
    @(negedge clk);
    rst           = 1'b0;
    bus.upd_valid = 1'b0;
    lookup(16'h0500, 1'b0, 1'b0, 16'h0504, "rst_upd_0500");
    lookup(16'h0104, 1'b0, 1'b0, 16'h0108, "rst_clr_0104");
    lookup(16'h0600, 1'b0, 1'b0, 16'h0604, "rst_clr_0600");
    lookup(16'hFFFC, 1'b0, 1'b0, 16'h0000, "rst_wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer for the fetch stage: the successor to the direct-mapped BTB. It predicts the next PC combinationally from the current fetch PC and is trained by the execute stage with resolved branch outcomes. Each entry carries a 2-bit hysteresis counter, and each set keeps a round-robin replacement pointer. On a miss or a not-taken prediction it falls back to PC+4.

## Interface
- PC_W, 16, PC width in bits; bits [1:0] are always zero and are not stored
- INDEX_W, 6, set index bits taken from PC[INDEX_W+1:2]; SETS = 2^INDEX_W
- WAYS, 2, associativity; legal values are 1, 2 or 4
- TAG_W, derived = PC_W-INDEX_W-2, tag bits PC[PC_W-1:INDEX_W+2]
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- pc  in  PC_W  fetch PC to predict
- npc_predict  out  PC_W  predicted next PC
- hit  out  1  tag match in a valid way of the indexed set
- pred_taken  out  1  hit and the prediction is taken
- upd_valid  in  1  training strobe from execute, one resolved branch per cycle
- upd_pc  in  PC_W  PC of the resolved branch
- upd_taken  in  1  actual branch outcome
- upd_target  in  PC_W  actual taken target; ignored when upd_taken=0

## Operation
- Entry fields: valid, tag[TAG_W], target[PC_W-2], ctr[2]. Per set: rr pointer[log2 WAYS], width 0 when WAYS=1 (omitted).
- Lookup is purely combinational:
  - Compare the tag in all ways of set pc[INDEX_W+1:2].
  - At most one way can match, because allocation never duplicates a tag.
  - pred_taken = hit & ctr[1].
  - npc_predict = pred_taken ? {target,2'b00} : pc+4, with the sum truncated to PC_W (wraps).
- Update when upd_valid=1, using upd_pc's set and tag:
  - Hit, taken: ctr saturating-increments (max 3); target <= upd_target[PC_W-1:2].
  - Hit, not taken: ctr saturating-decrements (min 0). The entry stays valid and the target is unchanged.
  - Miss, taken: allocate a way.
    - Victim is the lowest-numbered invalid way; if the set is full, the way at rr.
    - Write valid=1, tag, target, ctr=2'b10 (weakly taken).
    - rr <= rr+1 (mod WAYS) only when a full set was replaced.
  - Miss, not taken: no state change.
- upd_target low bits [1:0] are discarded.
- A single update touches exactly one way of one set.

## Timing
- Prediction has zero latency: the outputs depend only on pc and the current state.
- An update becomes visible to lookup on the cycle after the rising edge on which upd_valid was sampled.
- Same-cycle lookup and update of the same entry: the lookup returns the pre-update contents (read-old).
- Reset is a single cycle. At the edge with rst=1:
  - All valid bits, ctr and rr clear to 0.
  - upd_valid in that cycle is ignored.
- Reset during any training sequence discards all learned state; there is no partial state.
- Outputs after reset: hit=0, pred_taken=0, npc_predict=pc+4 for every pc.
- Storage is flop-based so that reset clears it in one cycle. Only valid, ctr and rr need reset; tag and target need not.

## Configuration
- BTB_ASSOC_CTR_EN defined: 2-bit counters are present; behaviour is as above.
- BTB_ASSOC_CTR_EN undefined: no ctr storage.
  - pred_taken = hit.
  - Hit, not taken: clear valid, which invalidates the entry.
  - Hit, taken: update target.
  - Allocation and replacement are unchanged.

## Test plan
- Reset, then lookup pc=0x0100 -> hit=0, npc_predict=0x0104. Lookup pc=0xFFFC -> npc_predict=0x0000 (wrap).
- Update pc=0x0100, taken, target=0x0200. Next cycle lookup 0x0100 -> hit=1, pred_taken=1, npc=0x0200. Same-cycle lookup during the update -> 0x0104.
- (CTR_EN) Train 0x0100 with T,T,N -> still taken (ctr 3->2). A further N -> ctr=1, hit=1, pred_taken=0, npc=0x0104. A following T -> taken again.
- WAYS=2, INDEX_W=6, same-set PCs 0x0100, 0x0200, 0x0300 each taken once:
  - 0x0300 evicts 0x0100 (rr=0); 0x0200 and 0x0300 hit, 0x0100 misses.
  - A fourth PC 0x0400 evicts 0x0200.
- Miss with upd_taken=0 at 0x0500 -> no allocation, lookup 0x0500 still misses. Update asserted in the same cycle as rst=1 -> no entry after reset.
- (CTR_EN undefined) Allocate 0x0100, then one not-taken update -> hit=0 on the next lookup, npc=0x0104.
